// File: rtl/ir_pkg.sv
// Shared types for NEC IR consumers: event kinds, event record and the default key-release timeout.
package ir_pkg;

    typedef enum logic [1:0] {
        EvPress   = 2'd0,
        EvRepeat  = 2'd1,
        EvRelease = 2'd2
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] addr;
        logic [7:0]  code;
    } ir_event_t;

    // 120 ms frame gap at the 25 MHz board clock.
    localparam int unsigned NEC_TIMEOUT_25MHZ = 3_000_000;

    function automatic logic nec_ok(logic [31:0] f, logic ext_addr);
        return (f[31:24] == ~f[23:16]) && (ext_addr || (f[15:8] == ~f[7:0]));
    endfunction

endpackage

// File: rtl/ir_event_fifo.sv
// Synchronous event FIFO with a registered head; a pop frees space for a same-cycle push when full.
module ir_event_fifo
    import ir_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  ir_event_t push_data,
    output logic      full,
    input  logic      pop,
    output logic      valid,
    output ir_event_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    ir_event_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
    logic [AW:0]   count, count_d;
    logic          do_push, do_pop;
    ir_event_t     head_d;

    assign full = (count == FULL_CNT);

    always_comb begin
        do_pop   = pop && (count != '0);
        do_push  = push && (!full || do_pop);
        rd_ptr_d = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        wr_ptr_d = do_push ? wr_ptr + AW'(1) : wr_ptr;
        count_d  = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        head_d   = '0;
        if (count_d != '0) begin
            // The new head slot is being written this cycle only when the queue was drained empty.
            if (do_push && (rd_ptr_d == wr_ptr)) head_d = push_data;
            else                                 head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_d;
            wr_ptr <= wr_ptr_d;
            count  <= count_d;
            valid  <= (count_d != '0);
            head   <= head_d;
        end
    end

endmodule

// File: rtl/ir_key_events.sv
// Turns decoded NEC frames into PRESS/REPEAT/RELEASE key events with hold tracking and a
// frame-gap release timeout; bad frames and FIFO overflow drops are counted.
module ir_key_events
    import ir_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = NEC_TIMEOUT_25MHZ,
    parameter bit          REPEAT_EN      = 1'b1,
    parameter bit          EXT_ADDR       = 1'b0,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_ready,
    input  logic [31:0] frame,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [1:0]  ev_kind,
    output logic [15:0] ev_addr,
    output logic [7:0]  ev_code,
    output logic        key_held,
    output logic [7:0]  err_count,
    output logic [7:0]  drop_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StHeld} state_e;

    state_e      state;
    logic [TW-1:0] timer;
    logic [31:0] s1_frame;
    logic        s1_valid, s1_ok;
    logic        pend_valid;
    ir_event_t   pend_ev;
    logic [15:0] held_addr;
    logic [7:0]  held_code;

    logic [15:0] f_addr;
    logic [7:0]  f_code;
    logic        same_key, take, expire, push, fifo_full, fifo_drop;
    ir_event_t   push_ev, fifo_head;

    always_comb begin
        f_addr   = EXT_ADDR ? s1_frame[15:0] : {8'h00, s1_frame[7:0]};
        f_code   = s1_frame[23:16];
        same_key = (f_addr == held_addr) && (f_code == held_code);
        // A pending PRESS owns the push slot; the stage-1 frame waits in place.
        take     = s1_valid && !pend_valid;
        expire   = (state == StHeld) && (timer == '0) && !pend_valid && !(s1_valid && s1_ok);
        push     = 1'b0;
        push_ev  = '{kind: EvPress, addr: f_addr, code: f_code};
        if (pend_valid) begin
            push    = 1'b1;
            push_ev = pend_ev;
        end else if (take && s1_ok) begin
            if (state == StIdle) begin
                push = 1'b1;
            end else if (!same_key) begin
                push    = 1'b1;
                push_ev = '{kind: EvRelease, addr: held_addr, code: held_code};
            end else begin
                push         = REPEAT_EN;
                push_ev.kind = EvRepeat;
            end
        end else if (expire) begin
            push    = 1'b1;
            push_ev = '{kind: EvRelease, addr: held_addr, code: held_code};
        end
    end

    assign fifo_drop = push && fifo_full && !(ev_valid && ev_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            key_held   <= 1'b0;
            timer      <= '0;
            s1_frame   <= '0;
            s1_valid   <= 1'b0;
            s1_ok      <= 1'b0;
            pend_valid <= 1'b0;
            pend_ev    <= '0;
            held_addr  <= '0;
            held_code  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (frame_ready) begin
                s1_frame <= frame;
                s1_ok    <= nec_ok(frame, EXT_ADDR);
                s1_valid <= 1'b1;
            end else if (take) begin
                s1_valid <= 1'b0;
            end
            if (take && !s1_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (fifo_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (pend_valid) pend_valid <= 1'b0;

            if (take && s1_ok) begin
                held_addr <= f_addr;
                held_code <= f_code;
                timer     <= TIMER_LOAD;
                state     <= StHeld;
                key_held  <= 1'b1;
                if (state == StHeld && !same_key) begin
                    pend_valid <= 1'b1;
                    pend_ev    <= '{kind: EvPress, addr: f_addr, code: f_code};
                end
            end else if (expire) begin
                state    <= StIdle;
                key_held <= 1'b0;
            end else if (state == StHeld && timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    ir_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_ev),
        .full     (fifo_full),
        .pop      (ev_ready),
        .valid    (ev_valid),
        .head     (fifo_head)
    );

    assign ev_kind = fifo_head.kind;
    assign ev_addr = fifo_head.addr;
    assign ev_code = fifo_head.code;

endmodule

// File: tb/tb_ir_key_events.sv
// Directed bench for ir_key_events: two instances differing only in REPEAT_EN share stimulus.
module tb_ir_key_events;

    localparam logic [31:0] KEY_A = 32'hF708FB04;
    localparam logic [31:0] KEY_B = 32'hE916FB04;
    localparam logic [31:0] BAD   = 32'hF709FB04;

    logic        clk = 1'b0;
    logic        rst, frame_ready, ev_ready;
    logic [31:0] frame;
    logic        ev_valid, key_held;
    logic [1:0]  ev_kind;
    logic [15:0] ev_addr;
    logic [7:0]  ev_code, err_count, drop_count;
    logic        nr_valid, nr_held;
    logic [1:0]  nr_kind;
    logic [15:0] nr_addr;
    logic [7:0]  nr_code, nr_err, nr_drop;

    int n_vec = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    ir_key_events #(
        .TIMEOUT_CYCLES(100), .REPEAT_EN(1'b1), .EXT_ADDR(1'b0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame(frame),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_addr(ev_addr),
        .ev_code(ev_code), .key_held(key_held), .err_count(err_count), .drop_count(drop_count)
    );

    ir_key_events #(
        .TIMEOUT_CYCLES(100), .REPEAT_EN(1'b0), .EXT_ADDR(1'b0), .FIFO_DEPTH(4)
    ) dut_nr (
        .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame(frame),
        .ev_valid(nr_valid), .ev_ready(ev_ready), .ev_kind(nr_kind), .ev_addr(nr_addr),
        .ev_code(nr_code), .key_held(nr_held), .err_count(nr_err), .drop_count(nr_drop)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send_frame(input logic [31:0] f);
        frame_ready = 1'b1;
        frame       = f;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_ready = 1'b0; ev_ready = 1'b0; frame = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({ev_valid, key_held, err_count, drop_count} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_status: got v=%b h=%b err=%0d drop=%0d want all 0",
                     ev_valid, key_held, err_count, drop_count);
        end
        n_vec++;
        if ({ev_kind, ev_addr, ev_code} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_head: got %h/%h/%h want 0/0/0", ev_kind, ev_addr, ev_code);
        end
    endtask

    task automatic test_single_press();
        logic prev_held;
        do_reset();
        n = 0;
        send_frame(KEY_A);
        n_vec++;
        if (ev_valid !== 1'b0) begin
            n_err++; $display("FAIL press_latency_early: got valid=%b want 0", ev_valid);
        end
        tick();
        n_vec++;
        if ({ev_valid, key_held, ev_kind, ev_addr, ev_code} !== {1'b1, 1'b1, 2'd0, 16'h4, 8'h08}) begin
            n_err++;
            $display("FAIL press_event: got v=%b h=%b %0d/%h/%h want 1 1 0/0004/08",
                     ev_valid, key_held, ev_kind, ev_addr, ev_code);
        end
        pop();
        prev_held = key_held;
        while (!ev_valid && n < 200) begin
            prev_held = key_held;
            tick();
        end
        n_vec++;
        if (n !== 102 || prev_held !== 1'b1 || key_held !== 1'b0) begin
            n_err++;
            $display("FAIL release_timing: got cycle %0d held_before=%b held=%b want 102 1 0",
                     n, prev_held, key_held);
        end
        n_vec++;
        if ({ev_kind, ev_addr, ev_code} !== {2'd2, 16'h4, 8'h08}) begin
            n_err++;
            $display("FAIL release_event: got %0d/%h/%h want 2/0004/08", ev_kind, ev_addr, ev_code);
        end
        pop();
    endtask

    task automatic test_hold();
        logic [25:0] exp_main [4];
        logic [25:0] exp_nr [2];
        exp_main = '{{2'd0, 16'h4, 8'h08}, {2'd1, 16'h4, 8'h08},
                     {2'd1, 16'h4, 8'h08}, {2'd2, 16'h4, 8'h08}};
        exp_nr   = '{{2'd0, 16'h4, 8'h08}, {2'd2, 16'h4, 8'h08}};
        do_reset();
        n = 0;
        send_frame(KEY_A);
        idle(49);
        send_frame(KEY_A);
        idle(49);
        send_frame(KEY_A);
        idle(100);
        n_vec++;
        if ({key_held, nr_held} !== 2'b11) begin
            n_err++; $display("FAIL hold_still_held: got %b%b want 11 at cycle %0d", key_held, nr_held, n);
        end
        tick();
        n_vec++;
        if ({key_held, nr_held} !== 2'b00) begin
            n_err++; $display("FAIL hold_released: got %b%b want 00 at cycle %0d", key_held, nr_held, n);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({ev_valid, ev_kind, ev_addr, ev_code} !== {1'b1, exp_main[i]}) begin
                n_err++;
                $display("FAIL hold_event%0d: got v=%b %0d/%h/%h want 1 %h",
                         i, ev_valid, ev_kind, ev_addr, ev_code, exp_main[i]);
            end
            if (i < 2) begin
                n_vec++;
                if ({nr_valid, nr_kind, nr_addr, nr_code} !== {1'b1, exp_nr[i]}) begin
                    n_err++;
                    $display("FAIL norepeat_event%0d: got v=%b %0d/%h/%h want 1 %h",
                             i, nr_valid, nr_kind, nr_addr, nr_code, exp_nr[i]);
                end
            end
            pop();
        end
        n_vec++;
        if ({ev_valid, nr_valid} !== 2'b00) begin
            n_err++; $display("FAIL hold_drained: got %b%b want 00", ev_valid, nr_valid);
        end
    endtask

    task automatic test_bad_frame();
        do_reset();
        send_frame(BAD);
        idle(3);
        n_vec++;
        if ({ev_valid, key_held, err_count} !== {1'b0, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL bad_idle: got v=%b h=%b err=%0d want 0 0 1", ev_valid, key_held, err_count);
        end
        n = 0;
        send_frame(KEY_A);
        tick();
        pop();
        idle(57);
        send_frame(BAD);
        idle(40);
        n_vec++;
        if ({ev_valid, key_held, err_count} !== {1'b0, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL bad_held: got v=%b h=%b err=%0d want 0 1 2 at cycle %0d",
                     ev_valid, key_held, err_count, n);
        end
        tick();
        n_vec++;
        if ({ev_valid, key_held, ev_kind} !== {1'b1, 1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL bad_no_reload: got v=%b h=%b kind=%0d want 1 0 2 at cycle %0d",
                     ev_valid, key_held, ev_kind, n);
        end
        pop();
        for (int i = 0; i < 298; i++) send_frame(BAD);
        idle(3);
        n_vec++;
        if (err_count !== 8'd255) begin
            n_err++; $display("FAIL err_saturate: got %0d want 255", err_count);
        end
    endtask

    task automatic test_key_change();
        logic [25:0] exp [3];
        exp = '{{2'd0, 16'h4, 8'h08}, {2'd2, 16'h4, 8'h08}, {2'd0, 16'h4, 8'h16}};
        do_reset();
        send_frame(KEY_A);
        idle(19);
        send_frame(KEY_B);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (key_held !== 1'b1) begin
                n_err++; $display("FAIL change_held%0d: got %b want 1", i, key_held);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({ev_valid, ev_kind, ev_addr, ev_code} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL change_event%0d: got v=%b %0d/%h/%h want 1 %h",
                         i, ev_valid, ev_kind, ev_addr, ev_code, exp[i]);
            end
            pop();
        end
        n_vec++;
        if (ev_valid !== 1'b0) begin
            n_err++; $display("FAIL change_drained: got %b want 0", ev_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp [4];
        exp = '{{2'd2, 16'h4, 8'h08}, {2'd0, 16'h4, 8'h16},
                {2'd2, 16'h4, 8'h16}, {2'd0, 16'h4, 8'h08}};
        do_reset();
        send_frame(KEY_A);
        tick();
        pop();
        idle(5);
        send_frame(KEY_B);
        send_frame(KEY_A);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({ev_valid, ev_kind, ev_addr, ev_code} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL b2b_event%0d: got v=%b %0d/%h/%h want 1 %h",
                         i, ev_valid, ev_kind, ev_addr, ev_code, exp[i]);
            end
            pop();
        end
        n_vec++;
        if ({ev_valid, key_held, drop_count} !== {1'b0, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL b2b_end: got v=%b h=%b drop=%0d want 0 1 0", ev_valid, key_held, drop_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  c;
        logic [25:0] exp [4];
        exp = '{{2'd0, 16'h4, 8'h01}, {2'd2, 16'h4, 8'h01},
                {2'd0, 16'h4, 8'h02}, {2'd2, 16'h4, 8'h02}};
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            c = 8'(i);
            send_frame({~c, c, 8'hFB, 8'h04});
            idle(9);
        end
        n_vec++;
        if (drop_count !== 8'd7) begin
            n_err++; $display("FAIL bp_drops: got %0d want 7", drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({ev_valid, ev_kind, ev_addr, ev_code} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL bp_event%0d: got v=%b %0d/%h/%h want 1 %h",
                         i, ev_valid, ev_kind, ev_addr, ev_code, exp[i]);
            end
            idle(3);
            n_vec++;
            if ({ev_valid, ev_kind, ev_addr, ev_code} !== {1'b1, exp[i]}) begin
                n_err++;
                $display("FAIL bp_stable%0d: got v=%b %0d/%h/%h want 1 %h",
                         i, ev_valid, ev_kind, ev_addr, ev_code, exp[i]);
            end
            pop();
        end
        n_vec++;
        if (ev_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got %b want 0", ev_valid);
        end
    endtask

    task automatic test_reset_held();
        do_reset();
        send_frame(KEY_A);
        idle(9);
        send_frame(KEY_A);
        idle(3);
        n_vec++;
        if ({ev_valid, key_held} !== 2'b11) begin
            n_err++; $display("FAIL rh_setup: got %b%b want 11", ev_valid, key_held);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({ev_valid, key_held} !== 2'b00) begin
            n_err++; $display("FAIL rh_cleared: got %b%b want 00", ev_valid, key_held);
        end
        idle(150);
        n_vec++;
        if ({ev_valid, key_held} !== 2'b00) begin
            n_err++; $display("FAIL rh_no_release: got %b%b want 00", ev_valid, key_held);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold();
        test_bad_frame();
        test_key_change();
        test_back_to_back();
        test_backpressure();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
